// File: rtl/pll_random_walk_filter.sv
// Random-walk loop-filter front end: integrates PD lead/lag into a signed walk, pulses inc/dec at +/-threshold.
// Latency: pulse is registered, high the cycle after the crossing sample; walk_o is the registered walk.
// Backpressure: none; every sample is consumed, or ignored while in hold-off or idle.
module pll_random_walk_filter #(
    parameter int CNT_WIDTH  = 6,
    parameter int HOLDOFF    = 0,
    parameter int HOLD_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 lead_i,
    input  logic                 lag_i,
    input  logic [CNT_WIDTH-1:0] threshold_i,
    output logic                 increment_o,
    output logic                 decrement_o,
    output logic [CNT_WIDTH:0]   walk_o,
    output logic                 holdoff_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLDOFF);
    localparam bit                    USE_HOLD  = (HOLDOFF > 0);

    state_t                       state_q;
    logic signed [CNT_WIDTH:0]    walk_q;
    logic signed [CNT_WIDTH:0]    walk_d;
    logic signed [CNT_WIDTH:0]    step;
    logic signed [CNT_WIDTH:0]    teff_pos;
    logic signed [CNT_WIDTH:0]    teff_neg;
    logic [CNT_WIDTH-1:0]         teff_q;
    logic [HOLD_WIDTH-1:0]        hold_q;
    logic                         increment_q;
    logic                         decrement_q;
    logic                         hit_pos;
    logic                         hit_neg;

    always_comb begin
        step = '0;
        if (lead_i && !lag_i) begin
            step = (CNT_WIDTH+1)'(1);
        end else if (lag_i && !lead_i) begin
            step = '1;
        end
    end

    // |walk_q| < T_eff always, so walk_q + step cannot leave the signed range.
    assign walk_d   = walk_q + step;
    assign teff_pos = $signed({1'b0, teff_q});
    assign teff_neg = -teff_pos;
    assign hit_pos  = (walk_d == teff_pos);
    assign hit_neg  = (walk_d == teff_neg);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            walk_q      <= '0;
            teff_q      <= CNT_WIDTH'(1);
            hold_q      <= '0;
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
        end else begin
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    walk_q <= '0;
                    hold_q <= '0;
                    if (enable_i) begin
                        state_q <= ST_RUN;
                        teff_q  <= (threshold_i == '0) ? CNT_WIDTH'(1) : threshold_i;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                        walk_q  <= '0;
                    end else if (hit_pos || hit_neg) begin
                        walk_q      <= '0;
                        increment_q <= hit_pos;
                        decrement_q <= hit_neg;
                        if (USE_HOLD) begin
                            state_q <= ST_HOLD;
                            hold_q  <= HOLD_LOAD;
                        end
                    end else begin
                        walk_q <= walk_d;
                    end
                end
                ST_HOLD: begin
                    walk_q <= '0;
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                        hold_q  <= '0;
                    end else begin
                        // Counter loaded with HOLDOFF gives exactly HOLDOFF cycles in HOLD.
                        hold_q <= hold_q - 1'b1;
                        if (hold_q == HOLD_WIDTH'(1)) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    walk_q  <= '0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign increment_o = increment_q;
    assign decrement_o = decrement_q;
    assign walk_o      = walk_q;
    assign holdoff_o   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pll_random_walk_filter.sv
// Bench for pll_random_walk_filter: two instances (no hold-off, hold-off of 3) on shared stimulus,
// checked every cycle against an integer reference model, plus directed checks of the key scenarios.
module tb_pll_random_walk_filter;

    localparam int CW = 6;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic          lead_i;
    logic          lag_i;
    logic [CW-1:0] threshold_i;

    logic          inc0, dec0, hold0;
    logic [CW:0]   walk0;
    logic          inc3, dec3, hold3;
    logic [CW:0]   walk3;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=idle 1=run 2=hold; index 0 has no hold-off, index 1 has hold-off 3.
    int hp[2]     = '{0, 3};
    int m_mode[2];
    int m_walk[2];
    int m_hcnt[2];
    int m_teff[2];
    int m_inc[2];
    int m_dec[2];

    always #5 clk_i = ~clk_i;

    pll_random_walk_filter #(.CNT_WIDTH(CW), .HOLDOFF(0), .HOLD_WIDTH(4)) u_dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .lead_i(lead_i), .lag_i(lag_i),
        .threshold_i(threshold_i), .increment_o(inc0), .decrement_o(dec0), .walk_o(walk0),
        .holdoff_o(hold0)
    );

    pll_random_walk_filter #(.CNT_WIDTH(CW), .HOLDOFF(3), .HOLD_WIDTH(4)) u_dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .lead_i(lead_i), .lag_i(lag_i),
        .threshold_i(threshold_i), .increment_o(inc3), .decrement_o(dec3), .walk_o(walk3),
        .holdoff_o(hold3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_walk[k] = 0; m_hcnt[k] = 0;
            m_teff[k] = 1; m_inc[k] = 0; m_dec[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit en, input bit ld, input bit lg, input int thr);
        int s;
        m_inc[k] = 0;
        m_dec[k] = 0;
        if (m_mode[k] == 0) begin
            m_walk[k] = 0;
            if (en) begin
                m_mode[k] = 1;
                m_teff[k] = (thr == 0) ? 1 : thr;
            end
        end else if (!en) begin
            m_mode[k] = 0;
            m_walk[k] = 0;
        end else if (m_mode[k] == 1) begin
            s = m_walk[k] + ((ld && !lg) ? 1 : (lg && !ld) ? -1 : 0);
            if (s == m_teff[k] || s == -m_teff[k]) begin
                m_inc[k]  = (s > 0) ? 1 : 0;
                m_dec[k]  = (s < 0) ? 1 : 0;
                m_walk[k] = 0;
                if (hp[k] > 0) begin
                    m_mode[k] = 2;
                    m_hcnt[k] = hp[k];
                end
            end else begin
                m_walk[k] = s;
            end
        end else begin
            m_walk[k] = 0;
            m_hcnt[k] = m_hcnt[k] - 1;
            if (m_hcnt[k] == 0) m_mode[k] = 1;
        end
    endtask

    task automatic check_all();
        chk("walk0", int'($signed(walk0)), m_walk[0]);
        chk("inc0",  int'(inc0),  m_inc[0]);
        chk("dec0",  int'(dec0),  m_dec[0]);
        chk("hold0", int'(hold0), (m_mode[0] == 2) ? 1 : 0);
        chk("walk3", int'($signed(walk3)), m_walk[1]);
        chk("inc3",  int'(inc3),  m_inc[1]);
        chk("dec3",  int'(dec3),  m_dec[1]);
        chk("hold3", int'(hold3), (m_mode[1] == 2) ? 1 : 0);
    endtask

    // Called at a negedge: drive inputs, let one rising edge sample them, check at the next negedge.
    task automatic cycle(input bit en, input bit ld, input bit lg, input int thr);
        enable_i    = en;
        lead_i      = ld;
        lag_i       = lg;
        threshold_i = CW'(thr);
        @(posedge clk_i);
        model_step(0, en, ld, lg, thr);
        model_step(1, en, ld, lg, thr);
        @(negedge clk_i);
        check_all();
    endtask

    initial begin
        int exp_walk[4];
        int last;
        bit en;
        bit ld;
        bit lg;
        int thr;

        exp_walk = '{1, 2, 3, 0};
        reset_i = 1'b0; enable_i = 1'b0; lead_i = 1'b0; lag_i = 1'b0; threshold_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all();
        reset_i = 1'b1;

        // Scenario 1: threshold 4, four leads.
        cycle(1, 0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 4);
            chk("t1_walk", int'($signed(walk0)), exp_walk[i]);
            chk("t1_inc", int'(inc0), (i == 3) ? 1 : 0);
        end
        cycle(1, 0, 0, 4);
        chk("t1_inc_end", int'(inc0), 0);

        // Scenario 2: alternating lead/lag never reaches threshold.
        for (int i = 0; i < 20; i++) begin
            cycle(1, (i % 2) == 0, (i % 2) == 1, 4);
            chk("t2_walk", int'($signed(walk0)), (i % 2 == 0) ? 1 : 0);
        end

        // Scenario 3: threshold 3, both high is no step, then lag crossing.
        cycle(0, 0, 0, 3);
        cycle(1, 0, 0, 3);
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 3);
        chk("t3_walk_both", int'($signed(walk0)), 0);
        cycle(1, 0, 1, 3);
        chk("t3_walk_m1", int'($signed(walk0)), -1);
        cycle(1, 0, 1, 3);
        chk("t3_walk_m2", int'($signed(walk0)), -2);
        cycle(1, 0, 1, 3);
        chk("t3_dec", int'(dec0), 1);

        // Scenario 4: hold-off 3, threshold 2, pulses five cycles apart.
        cycle(0, 0, 0, 2);
        cycle(1, 0, 0, 2);
        last = -1;
        for (int i = 0; i < 14; i++) begin
            cycle(1, 1, 0, 2);
            if (inc3) begin
                if (last >= 0) chk("t4_gap", i - last, 5);
                last = i;
            end
        end
        chk("t4_pulsed", (last >= 0) ? 1 : 0, 1);

        // Scenario 5: threshold 0 acts as 1; mid-run threshold change ignored.
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0);
            chk("t5_inc", int'(inc0), 1);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 0, 5);
            chk("t5_inc_keep", int'(inc0), 1);
        end
        cycle(0, 0, 0, 5);
        cycle(1, 0, 0, 5);
        cycle(1, 1, 0, 5);
        chk("t5_new_teff", int'($signed(walk0)), 1);

        // Scenario 6: enable drop on the crossing edge suppresses the pulse.
        cycle(0, 0, 0, 4);
        cycle(1, 0, 0, 4);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 4);
        chk("t6_walk3", int'($signed(walk0)), 3);
        cycle(0, 1, 0, 4);
        chk("t6_noinc", int'(inc0), 0);
        chk("t6_walk0", int'($signed(walk0)), 0);

        // Async reset in the middle of hold-off.
        cycle(1, 0, 0, 2);
        cycle(1, 1, 0, 2);
        cycle(1, 1, 0, 2);
        cycle(1, 0, 0, 2);
        chk("t6_in_hold", int'(hold3), 1);
        #2 reset_i = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_hold", int'(hold3), 0);
        chk("t6_rst_walk", int'($signed(walk3)), 0);
        chk("t6_rst_inc", int'(inc3) + int'(dec3), 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        cycle(0, 1, 0, 2);
        chk("t6_idle", int'($signed(walk3)) + int'(hold3), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 39) != 0);
            ld  = $urandom_range(0, 1);
            lg  = $urandom_range(0, 1);
            thr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            cycle(en, ld, lg, thr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
